// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-class front-panel LCD writer.
package lcd_pkg;

   typedef enum logic [1:0] {
      TOP_PWRUP,
      TOP_RUN,
      TOP_IDLE
   } top_state_t;

   typedef enum logic [1:0] {
      STB_IDLE,
      STB_SETUP,
      STB_EHIGH,
      STB_WAIT
   } stb_state_t;

   localparam logic [7:0] CMD_FUNC_SET  = 8'h38;
   localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
   localparam logic [7:0] CMD_CLEAR     = 8'h01;
   localparam logic [7:0] CMD_ENTRY     = 8'h06;
   localparam logic [7:0] CMD_DDRAM0    = 8'h80;
   localparam logic [7:0] ASCII_ZERO    = 8'h30;
   localparam logic [7:0] ASCII_HEX_OFS = 8'h37;

   // Values 10..15 become 'A'..'F' only when hex rendering is enabled.
   function automatic logic [7:0] digit_ascii(input logic [3:0] v, input logic hex_en);
      if (hex_en && (v > 4'd9))
         return ASCII_HEX_OFS + {4'h0, v};
      return ASCII_ZERO + {4'h0, v};
   endfunction

endpackage

// File: rtl/lcd_byte_strobe.sv
// Drives one LCD byte: SETUP, E-high pulse, then the post-strobe wait.
module lcd_byte_strobe
   import lcd_pkg::*;
#(
   parameter int unsigned E_PULSE_CYC  = 12,
   parameter int unsigned CMD_WAIT_CYC = 2000,
   parameter int unsigned CLR_WAIT_CYC = 82000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] db,
   input  logic       rs,
   input  logic       long_wait,
   output logic [7:0] lcd_db,
   output logic       lcd_rs,
   output logic       lcd_e,
   output logic       byte_done
);

   localparam int unsigned MAX_A = (E_PULSE_CYC > CMD_WAIT_CYC) ? E_PULSE_CYC : CMD_WAIT_CYC;
   localparam int unsigned MAX_W = (MAX_A > CLR_WAIT_CYC) ? MAX_A : CLR_WAIT_CYC;
   localparam int unsigned CW    = $clog2(MAX_W + 1);

   stb_state_t    state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [CW-1:0] wait_last;
   logic          load;
   logic          long_q;

   assign wait_last = long_q ? CW'(CLR_WAIT_CYC - 1) : CW'(CMD_WAIT_CYC - 1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= STB_IDLE;
         cnt    <= '0;
         lcd_db <= '0;
         lcd_rs <= 1'b0;
         lcd_e  <= 1'b0;
         long_q <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         lcd_e <= (state_nx == STB_EHIGH);
         if (load) begin
            lcd_db <= db;
            lcd_rs <= rs;
            long_q <= long_wait;
         end
      end
   end

   // A start on the last WAIT cycle chains straight into the next SETUP.
   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      load      = 1'b0;
      byte_done = 1'b0;
      case (state)
         STB_IDLE: begin
            if (start) begin
               load     = 1'b1;
               state_nx = STB_SETUP;
               cnt_nx   = '0;
            end
         end
         STB_SETUP: begin
            state_nx = STB_EHIGH;
            cnt_nx   = '0;
         end
         STB_EHIGH: begin
            if (cnt == CW'(E_PULSE_CYC - 1)) begin
               state_nx = STB_WAIT;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         STB_WAIT: begin
            if (cnt == wait_last) begin
               byte_done = 1'b1;
               cnt_nx    = '0;
               if (start) begin
                  load     = 1'b1;
                  state_nx = STB_SETUP;
               end else begin
                  state_nx = STB_IDLE;
               end
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         default: state_nx = STB_IDLE;
      endcase
   end

endmodule

// File: rtl/lcd_digit_writer.sv
// Self-sequencing LCD writer: power-up wait, init commands, then digit frames on request.
module lcd_digit_writer
   import lcd_pkg::*;
#(
   parameter int unsigned N_DIGITS     = 4,
   parameter int unsigned HEX_EN       = 0,
   parameter int unsigned POWERUP_CYC  = 750000,
   parameter int unsigned E_PULSE_CYC  = 12,
   parameter int unsigned CMD_WAIT_CYC = 2000,
   parameter int unsigned CLR_WAIT_CYC = 82000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [4*N_DIGITS-1:0] digits,
   input  logic                  update,
   output logic [7:0]            lcd_db,
   output logic                  lcd_rs,
   output logic                  lcd_rw,
   output logic                  lcd_e,
   output logic                  ready,
   output logic                  busy,
   output logic                  frame_done
);

   localparam int unsigned N_BYTES = 5 + N_DIGITS;
   localparam int unsigned IW      = $clog2(N_BYTES);
   localparam int unsigned PW      = $clog2(POWERUP_CYC + 1);

   top_state_t            state, state_nx;
   logic [PW-1:0]         pw_cnt;
   logic [IW-1:0]         idx;
   logic [IW-1:0]         sel;
   logic                  pending;
   logic [4*N_DIGITS-1:0] snap;
   logic [3:0]            digit_v;
   logic [7:0]            db_sel;
   logic                  rs_sel;
   logic                  pw_done, frame_go, last_byte, start, byte_done;

   assign lcd_rw    = 1'b0;
   assign pw_done   = (state == TOP_PWRUP) && (pw_cnt == PW'(POWERUP_CYC - 1));
   assign frame_go  = (state == TOP_IDLE) && (pending || update);
   assign last_byte = byte_done && (idx == IW'(N_BYTES - 1));
   assign start     = pw_done || frame_go || (byte_done && !last_byte);

   // Byte selection looks one step ahead so the next SETUP follows WAIT without a gap.
   always_comb begin
      sel = idx + IW'(1);
      if (pw_done)
         sel = '0;
      else if (frame_go)
         sel = IW'(4);
      digit_v = '0;
      for (int unsigned i = 0; i < N_DIGITS; i++)
         if (sel == IW'(4 + N_DIGITS - i))
            digit_v = snap[4*i +: 4];
      rs_sel = 1'b0;
      if (sel == IW'(0))      db_sel = CMD_FUNC_SET;
      else if (sel == IW'(1)) db_sel = CMD_DISP_ON;
      else if (sel == IW'(2)) db_sel = CMD_CLEAR;
      else if (sel == IW'(3)) db_sel = CMD_ENTRY;
      else if (sel == IW'(4)) db_sel = CMD_DDRAM0;
      else begin
         db_sel = digit_ascii(digit_v, HEX_EN != 0);
         rs_sel = 1'b1;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         TOP_PWRUP: if (pw_done)   state_nx = TOP_RUN;
         TOP_RUN:   if (last_byte) state_nx = TOP_IDLE;
         TOP_IDLE:  if (frame_go)  state_nx = TOP_RUN;
         default:   state_nx = TOP_PWRUP;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= TOP_PWRUP;
         pw_cnt     <= '0;
         idx        <= '0;
         pending    <= 1'b1;
         snap       <= '0;
         ready      <= 1'b0;
         busy       <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nx;
         frame_done <= 1'b0;
         if (update && busy)
            pending <= 1'b1;
         case (state)
            TOP_PWRUP: begin
               if (pw_done) idx <= '0;
               else         pw_cnt <= pw_cnt + PW'(1);
            end
            TOP_RUN: begin
               if (last_byte) begin
                  busy       <= 1'b0;
                  frame_done <= 1'b1;
               end else if (byte_done) begin
                  idx <= idx + IW'(1);
                  // Init just finished; the first frame starts here and consumes the pending request.
                  if (idx == IW'(3)) begin
                     ready   <= 1'b1;
                     pending <= 1'b0;
                     snap    <= digits;
                  end
               end
            end
            TOP_IDLE: begin
               if (frame_go) begin
                  idx     <= IW'(4);
                  busy    <= 1'b1;
                  pending <= 1'b0;
                  snap    <= digits;
               end
            end
            default: ;
         endcase
      end
   end

   lcd_byte_strobe #(
      .E_PULSE_CYC (E_PULSE_CYC),
      .CMD_WAIT_CYC(CMD_WAIT_CYC),
      .CLR_WAIT_CYC(CLR_WAIT_CYC)
   ) u_strobe (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .db       (db_sel),
      .rs       (rs_sel),
      .long_wait(sel == IW'(2)),
      .lcd_db   (lcd_db),
      .lcd_rs   (lcd_rs),
      .lcd_e    (lcd_e),
      .byte_done(byte_done)
   );

endmodule
